// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// lsu -- load/store unit driving the SISC data memory port
// Revision: 1.0
// ============================================================================
module lsu #(
  parameter int RD_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [15:0] dm_read_addr,
  output logic [15:0] dm_write_addr,
  output logic [31:0] dm_write_data,
  output logic        dm_we,
  input  logic [31:0] dm_read_data
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_RD_RSP   = 3'd2,
    S_WR_SETUP = 3'd3,
    S_WR_PULSE = 3'd4,
    S_WR_DONE  = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_alive;
  logic  [3:0] r_cnt;

  assign req_ready = r_alive && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state       <= S_IDLE;
      r_alive       <= 1'b0;
      r_cnt         <= 4'd0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      dm_read_addr  <= 16'd0;
      dm_write_addr <= 16'd0;
      dm_write_data <= 32'd0;
      dm_we         <= 1'b0;
    end else begin
      r_alive   <= 1'b1;
      rsp_valid <= 1'b0;
      dm_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            if (req_we) begin
              dm_write_addr <= req_addr;
              dm_write_data <= req_wdata;
              r_state       <= S_WR_SETUP;
            end else begin
              dm_read_addr <= req_addr;
              r_cnt        <= 4'(RD_WAIT);
              r_state      <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            rsp_rdata <= dm_read_data;
            rsp_valid <= 1'b1;
            r_state   <= S_RD_RSP;
          end
        end
        S_RD_RSP: r_state <= S_IDLE;
        S_WR_SETUP: begin
          dm_we   <= 1'b1;
          r_state <= S_WR_PULSE;
        end
        // dm_we falls on this edge, committing the write while the response goes out
        S_WR_PULSE: begin
          rsp_valid <= 1'b1;
          r_state   <= S_WR_DONE;
        end
        S_WR_DONE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit for the SISC datapath: the initiator side of the data memory port. It accepts one load or store request at a time from the control unit over a valid/ready handshake. It drives the data memory's read address, write address, write data and write-enable lines, timing the write-enable pulse so the memory commits on its falling edge. For loads it waits a fixed settle time, then registers the returned word and reports completion with a one-cycle response strobe.

## Interface
- RD_WAIT, 1, cycles `dm_read_addr` is held before `dm_read_data` is captured; legal range 1..15.
- clk  in  1  system clock; all state changes on rising edge.
- rst_f  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  16  word address.
- req_wdata  in  32  store data; ignored for loads.
- rsp_valid  out  1  one-cycle completion strobe, for loads and stores.
- rsp_rdata  out  32  load result; valid when `rsp_valid` is high after a load.
- dm_read_addr  out  16  to memory read address.
- dm_write_addr  out  16  to memory write address.
- dm_write_data  out  32  to memory write data.
- dm_we  out  1  to memory write enable; the memory commits on the 1→0 transition.
- dm_read_data  in  32  from memory read data; combinational in the memory.

## Operation
- **State machine:** IDLE, RD_WAIT, RD_RSP, WR_SETUP, WR_PULSE, WR_DONE. All outputs are registered or decoded from the state register; there are no combinational paths from request inputs to outputs.
- **Reset (rst_f low):** applies asynchronously.
  - State goes to IDLE.
  - `req_ready`=0, `rsp_valid`=0, `dm_we`=0.
  - `rsp_rdata`, `dm_read_addr`, `dm_write_addr` and `dm_write_data` all go to 0.
  - A registered `alive` flag clears; it sets on the first clk edge with `rst_f` high.
  - `req_ready` = `alive` & (state==IDLE).
- **Accept:** a request is taken when `req_valid` & `req_ready` are high at a clk edge. `req_we`, `req_addr` and `req_wdata` are sampled only at that edge. `req_valid` without `req_ready` is ignored, and the requester holds the request.
- **Load:**
  - At accept, `dm_read_addr` ← `req_addr`, a 4-bit wait counter ← RD_WAIT, and the state goes to RD_WAIT.
  - The counter decrements each edge in RD_WAIT.
  - On the edge where the counter equals 1, `rsp_rdata` ← `dm_read_data` and the state goes to RD_RSP.
  - RD_RSP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- **Store:**
  - At accept, `dm_write_addr` ← `req_addr`, `dm_write_data` ← `req_wdata`, and the state goes to WR_SETUP with `dm_we`=0. This gives one cycle of address/data setup.
  - WR_PULSE: `dm_we`=1 for exactly one cycle.
  - WR_DONE: `dm_we`=0, so the falling edge commits the write, and `rsp_valid`=1. Then IDLE.
- **Held outputs:**
  - `dm_read_addr` changes only on load accept; stores never move it.
  - `dm_write_addr` and `dm_write_data` change only on store accept.
  - `rsp_rdata` changes only at load capture and holds its value through stores.
- **Read-after-write:** a load accepted after a store's WR_DONE to the same address returns the new data. `dm_we` falls before `dm_read_addr` is updated.
- **Reset mid-operation:**
  - During RD_*: the load is abandoned; no `rsp_valid`.
  - During WR_SETUP: no write occurs, because `dm_we` never rose.
  - During WR_PULSE: the forced `dm_we` 1→0 commits the write to memory. No `rsp_valid` is issued, and the requester treats the write as done.

## Timing
- **Edge numbering:** E0 is the accept edge; cycle k is the cycle after edge Ek.
- **Load:**
  - RD_WAIT occupies cycles 0..RD_WAIT-1.
  - Capture happens at edge E(RD_WAIT).
  - `rsp_valid` is high in cycle RD_WAIT.
  - IDLE at E(RD_WAIT+1); next accept no earlier than E(RD_WAIT+2).
  - With RD_WAIT=1: `rsp_valid` in cycle 1, next accept at E3.
- **Store:**
  - `dm_we` is high in cycle 1 only.
  - `rsp_valid` is high in cycle 2.
  - IDLE at E3; next accept no earlier than E4.
- **Response strobe:** `rsp_valid` is never high for two consecutive cycles.
- **req_ready:** low from the cycle after accept until IDLE is re-entered.

## Test plan
- **Reset then idle:** hold rst_f=0 for 3 cycles, then release.
  - All outputs are 0 during reset.
  - `req_ready`=1 from the first edge after release.
- **Store:** addr 0x0010, data 0xDEADBEEF.
  - `dm_we` is high exactly in cycle 1.
  - `dm_write_addr`=0x0010 and `dm_write_data`=0xDEADBEEF are stable cycles 0..2.
  - `rsp_valid` is high in cycle 2.
  - Memory word 0x0010 = 0xDEADBEEF.
- **Back-to-back store then load, same address:** store 0x0020←0x12345678, then a load of 0x0020 presented continuously.
  - The load is accepted at E4.
  - `rsp_rdata`=0x12345678 with `rsp_valid` in cycle RD_WAIT.
  - `dm_read_addr` does not move during the store.
- **RD_WAIT=3 load:** load 0x0003 with memory preset to 0xA5A5A5A5.
  - `rsp_valid` is high only in cycle 3.
  - `rsp_rdata`=0xA5A5A5A5 and holds through a following store.
- **Busy hold:** assert `req_valid` continuously during a load.
  - Second request is accepted only at E(RD_WAIT+2).
  - Exactly one `rsp_valid` per request.
- **Reset during WR_PULSE:** store 0x0030←0x0000BEEF.
  - `dm_we` drops immediately and the memory holds 0x0000BEEF.
  - No `rsp_valid`.
  - `req_ready`=1 one edge after `rst_f` rises.
